program_loader: RTL and testbench

Serial boot loader that fills the 3-bit CPU's 8×9-bit program RAM through its external write port (RAM write data/address/enable) and gates CPU execution. It receives 9-bit instruction words over a single-wire asynchronous serial line and writes them to RAM addresses 0..DEPTH-1 in order. While loading, it holds PC_Enable low. After the last word it issues a one-cycle CPU_Reset pulse and then raises PC_Enable so the CPU runs the freshly loaded program from address 0.

---
 rtl/loader_pkg.sv | 22 ++
 rtl/serial_rx_word.sv | 112 +++++++++++
 rtl/program_loader.sv | 148 ++++++++++++++
 tb/tb_program_loader.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and default sizing for the serial program loader.
package loader_pkg;

  localparam int DATA_W = 9;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    KICK = 2'd2,
    RUN  = 2'd3
  } ctrl_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/serial_rx_word.sv
// Word-wide asynchronous serial receiver: start bit, DATA_W bits LSB first, stop bit.
module serial_rx_word #(
  parameter int DATA_W       = 9,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              abort_i,
  input  logic              ser_i,
  output logic              word_valid_o,
  output logic [DATA_W-1:0] word_o,
  output logic              frame_err_o
);
  import loader_pkg::*;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  logic [1:0]        sync_q;
  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              line;
  logic              word_valid;
  logic              frame_err;

  assign line = sync_q[1];

  // Synchronizer, bit timing and receiver state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], ser_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Receiver next state; a start sample of 1 is treated as a line glitch
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    word_valid = 1'b0;
    frame_err  = 1'b0;
    if (abort_i) begin
      state_d = RX_IDLE;
      cnt_d   = '0;
      bit_d   = '0;
    end else begin
      case (state_q)
        RX_IDLE: begin
          cnt_d = '0;
          bit_d = '0;
          if (!line) state_d = RX_START;
          else       state_d = RX_IDLE;
        end
        RX_START: begin
          if (cnt_q == HALF_END) begin
            cnt_d = '0;
            if (!line) state_d = RX_DATA;
            else       state_d = RX_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == BIT_END) begin
            cnt_d   = '0;
            shift_d = {line, shift_q[DATA_W-1:1]};
            if (bit_q == LAST_BIT) state_d = RX_STOP;
            else                   bit_d   = bit_q + BIT_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt_q == BIT_END) begin
            cnt_d   = '0;
            state_d = RX_IDLE;
            if (line) word_valid = 1'b1;
            else      frame_err  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = RX_IDLE;
          cnt_d   = '0;
          bit_d   = '0;
        end
      endcase
    end
  end

  assign word_valid_o = word_valid;
  assign frame_err_o  = frame_err;
  assign word_o       = shift_q;

endmodule

// File: rtl/program_loader.sv
// Serial boot loader: fills program RAM rows 0..DEPTH-1, then resets and releases the CPU.
module program_loader #(
  parameter int DATA_W       = 9,
  parameter int ADDR_W       = 3,
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Load_Start,
  input  logic              Ser_In,
  output logic [DATA_W-1:0] RAM_Write_Data,
  output logic [ADDR_W-1:0] RAM_Write_Address,
  output logic              RAM_Write_Enable,
  output logic              PC_Enable,
  output logic              CPU_Reset,
  output logic              Loading,
  output logic              Frame_Err
);
  import loader_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ctrl_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic              pc_en_q, pc_en_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              loading_q, loading_d;
  logic              ferr_q, ferr_d;

  logic              rx_abort;
  logic              rx_valid;
  logic              rx_ferr;
  logic [DATA_W-1:0] rx_word;

  // Receiver only listens while loading; a restart kills any frame in flight
  assign rx_abort = Load_Start | (state_q != LOAD);

  serial_rx_word #(
    .DATA_W      (DATA_W),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .abort_i     (rx_abort),
    .ser_i       (Ser_In),
    .word_valid_o(rx_valid),
    .word_o      (rx_word),
    .frame_err_o (rx_ferr)
  );

  // Control state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      pc_en_q   <= 1'b0;
      cpu_rst_q <= 1'b0;
      loading_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_q      <= we_d;
      pc_en_q   <= pc_en_d;
      cpu_rst_q <= cpu_rst_d;
      loading_q <= loading_d;
      ferr_q    <= ferr_d;
    end
  end

  // Load_Start has priority everywhere; a strobe already out still completes
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we_d      = 1'b0;
    pc_en_d   = pc_en_q;
    cpu_rst_d = 1'b0;
    loading_d = loading_q;
    ferr_d    = ferr_q;
    if (Load_Start) begin
      state_d   = LOAD;
      addr_d    = '0;
      ferr_d    = 1'b0;
      pc_en_d   = 1'b0;
      loading_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          pc_en_d   = 1'b0;
          loading_d = 1'b0;
        end
        LOAD: begin
          pc_en_d = 1'b0;
          if (we_q) begin
            if (addr_q == LAST_ADDR) begin
              // Address holds at the last row so the counter never wraps
              state_d   = KICK;
              cpu_rst_d = 1'b1;
              loading_d = 1'b0;
            end else begin
              addr_d = addr_q + ADDR_W'(1);
            end
          end else begin
            addr_d = addr_q;
          end
          if (rx_valid) begin
            we_d   = 1'b1;
            data_d = rx_word;
          end else if (rx_ferr) begin
            ferr_d = 1'b1;
          end else begin
            we_d = 1'b0;
          end
        end
        KICK: begin
          state_d   = RUN;
          pc_en_d   = 1'b1;
          loading_d = 1'b0;
        end
        RUN: begin
          pc_en_d   = 1'b1;
          loading_d = 1'b0;
        end
        default: begin
          state_d   = IDLE;
          pc_en_d   = 1'b0;
          loading_d = 1'b0;
        end
      endcase
    end
  end

  assign RAM_Write_Data    = data_q;
  assign RAM_Write_Address = addr_q;
  assign RAM_Write_Enable  = we_q;
  assign PC_Enable         = pc_en_q;
  assign CPU_Reset         = cpu_rst_q;
  assign Loading           = loading_q;
  assign Frame_Err         = ferr_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader at 4 clocks per serial bit.
module tb_program_loader;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Load_Start = 1'b0;
  logic       Ser_In = 1'b1;
  logic [8:0] RAM_Write_Data;
  logic [2:0] RAM_Write_Address;
  logic       RAM_Write_Enable;
  logic       PC_Enable;
  logic       CPU_Reset;
  logic       Loading;
  logic       Frame_Err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int log_addr[$];
  int log_data[$];
  int log_cyc[$];
  int kick_cyc[$];
  int kick_load[$];
  int kick_pc[$];
  int pc_rise[$];
  logic pc_prev = 1'b0;

  program_loader #(
    .DATA_W(9), .ADDR_W(3), .DEPTH(8), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk), .reset(reset), .Load_Start(Load_Start), .Ser_In(Ser_In),
    .RAM_Write_Data(RAM_Write_Data), .RAM_Write_Address(RAM_Write_Address),
    .RAM_Write_Enable(RAM_Write_Enable), .PC_Enable(PC_Enable),
    .CPU_Reset(CPU_Reset), .Loading(Loading), .Frame_Err(Frame_Err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled mid-cycle
  always @(negedge clk) begin
    if (RAM_Write_Enable === 1'b1) begin
      log_addr.push_back(int'(RAM_Write_Address));
      log_data.push_back(int'(RAM_Write_Data));
      log_cyc.push_back(cyc);
    end
    if (CPU_Reset === 1'b1) begin
      kick_cyc.push_back(cyc);
      kick_load.push_back(int'(Loading));
      kick_pc.push_back(int'(PC_Enable));
    end
    if (PC_Enable === 1'b1 && pc_prev !== 1'b1) pc_rise.push_back(cyc);
    pc_prev <= PC_Enable;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    Ser_In = v;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [8:0] w, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 9; i++) send_bit(w[i]);
    send_bit(stop);
    Ser_In = 1'b1;
  endtask

  task automatic pulse_start();
    Load_Start = 1'b1;
    tick(1);
    Load_Start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    checks++;
    if ({RAM_Write_Data, RAM_Write_Address, RAM_Write_Enable, PC_Enable, CPU_Reset, Loading, Frame_Err} !== 17'd0) begin
      errors++;
      $display("FAIL reset_values: got data=%h addr=%0d we=%b pc=%b cpurst=%b loading=%b ferr=%b, want all 0",
               RAM_Write_Data, RAM_Write_Address, RAM_Write_Enable, PC_Enable, CPU_Reset, Loading, Frame_Err);
    end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_full_load();
    logic [8:0] frames [8];
    int base, kbase, pbase, last;
    frames = '{9'h1A5, 9'h003, 9'h0F0, 9'h155, 9'h0AA, 9'h100, 9'h07E, 9'h1FF};
    base = log_addr.size(); kbase = kick_cyc.size(); pbase = pc_rise.size();
    pulse_start();
    checks++;
    if (Loading !== 1'b1 || PC_Enable !== 1'b0 || RAM_Write_Address !== 3'd0) begin
      errors++;
      $display("FAIL load_entry: got loading=%b pc=%b addr=%0d, want 1 0 0", Loading, PC_Enable, RAM_Write_Address);
    end
    for (int i = 0; i < 8; i++) begin
      send_frame(frames[i], 1'b1);
      tick(2);
    end
    tick(10);
    checks++;
    if (log_addr.size() - base !== 8) begin
      errors++;
      $display("FAIL full_strobes: got %0d strobes, want 8", log_addr.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (log_addr[base+i] !== i || log_data[base+i] !== int'(frames[i])) begin
          errors++;
          $display("FAIL full_write%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                   i, log_addr[base+i], log_data[base+i], i, frames[i]);
        end
      end
      last = log_cyc[base+7];
      checks++;
      if (kick_cyc.size() - kbase !== 1) begin
        errors++;
        $display("FAIL kick_count: got %0d CPU_Reset cycles, want 1", kick_cyc.size() - kbase);
      end else begin
        checks++;
        if (kick_cyc[kbase] !== last + 1 || kick_load[kbase] !== 0 || kick_pc[kbase] !== 0) begin
          errors++;
          $display("FAIL kick_timing: got cyc=%0d loading=%0d pc=%0d, want cyc=%0d loading=0 pc=0",
                   kick_cyc[kbase], kick_load[kbase], kick_pc[kbase], last + 1);
        end
        checks++;
        if (pc_rise.size() - pbase !== 1 || pc_rise[pbase] !== last + 2) begin
          errors++;
          $display("FAIL pc_rise: got %0d rises, first at %0d, want 1 at %0d",
                   pc_rise.size() - pbase, (pc_rise.size() > pbase) ? pc_rise[pbase] : -1, last + 2);
        end
      end
    end
    checks++;
    if (PC_Enable !== 1'b1 || CPU_Reset !== 1'b0 || Loading !== 1'b0) begin
      errors++;
      $display("FAIL run_state: got pc=%b cpurst=%b loading=%b, want 1 0 0", PC_Enable, CPU_Reset, Loading);
    end
  endtask

  task automatic test_run_ignores_line();
    int base;
    base = log_addr.size();
    send_frame(9'h0AB, 1'b1);
    tick(10);
    checks++;
    if (log_addr.size() !== base || PC_Enable !== 1'b1) begin
      errors++;
      $display("FAIL run_ignore: got strobes=%0d pc=%b, want 0 1", log_addr.size() - base, PC_Enable);
    end
    pulse_start();
    checks++;
    if (PC_Enable !== 1'b0 || Loading !== 1'b1 || RAM_Write_Address !== 3'd0) begin
      errors++;
      $display("FAIL run_restart: got pc=%b loading=%b addr=%0d, want 0 1 0", PC_Enable, Loading, RAM_Write_Address);
    end
  endtask

  task automatic test_frame_err();
    int base;
    base = log_addr.size();
    pulse_start();
    send_frame(9'h0AA, 1'b1); tick(2);
    send_frame(9'h155, 1'b1); tick(2);
    send_frame(9'h0F0, 1'b0); tick(4);
    checks++;
    if (Frame_Err !== 1'b1 || log_addr.size() - base !== 2 || RAM_Write_Address !== 3'd2) begin
      errors++;
      $display("FAIL ferr_set: got ferr=%b strobes=%0d addr=%0d, want 1 2 2",
               Frame_Err, log_addr.size() - base, RAM_Write_Address);
    end
    send_frame(9'h123, 1'b1); tick(4);
    checks++;
    if (log_addr.size() - base !== 3) begin
      errors++;
      $display("FAIL ferr_next_count: got %0d strobes, want 3", log_addr.size() - base);
    end else if (log_addr[base+2] !== 2 || log_data[base+2] !== 'h123 || Frame_Err !== 1'b1) begin
      errors++;
      $display("FAIL ferr_next_write: got addr=%0d data=%h ferr=%b, want 2 123 1",
               log_addr[base+2], log_data[base+2], Frame_Err);
    end
  endtask

  task automatic test_glitch();
    int base;
    base = log_addr.size();
    Ser_In = 1'b0;
    tick(1);
    Ser_In = 1'b1;
    tick(12);
    checks++;
    if (log_addr.size() !== base || RAM_Write_Address !== 3'd3 || Loading !== 1'b1) begin
      errors++;
      $display("FAIL glitch: got strobes=%0d addr=%0d loading=%b, want 0 3 1",
               log_addr.size() - base, RAM_Write_Address, Loading);
    end
    send_frame(9'h1E1, 1'b1); tick(4);
    checks++;
    if (log_addr.size() - base !== 1 || log_addr[log_addr.size()-1] !== 3 || log_data[log_data.size()-1] !== 'h1E1) begin
      errors++;
      $display("FAIL glitch_recover: got strobes=%0d last addr=%0d data=%h, want 1 3 1e1",
               log_addr.size() - base, log_addr[log_addr.size()-1], log_data[log_data.size()-1]);
    end
  endtask

  task automatic test_start_on_strobe();
    int base;
    bit found;
    base = log_addr.size();
    found = 1'b0;
    send_frame(9'h07E, 1'b1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (RAM_Write_Enable === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL strobe_wait: got no strobe within 12 cycles, want one");
    end else begin
      Load_Start = 1'b1;
      @(posedge clk);
      #1;
      Load_Start = 1'b0;
      checks++;
      if (RAM_Write_Address !== 3'd0 || log_addr.size() - base !== 1 || log_addr[base] !== 4 || log_data[base] !== 'h07E) begin
        errors++;
        $display("FAIL start_on_strobe: got addr=%0d strobes=%0d, want addr 0 and one write of 07e to 4",
                 RAM_Write_Address, log_addr.size() - base);
      end
      send_frame(9'h100, 1'b1); tick(4);
      checks++;
      if (log_addr.size() - base !== 2 || log_addr[log_addr.size()-1] !== 0 || log_data[log_data.size()-1] !== 'h100) begin
        errors++;
        $display("FAIL after_strobe_restart: got strobes=%0d last addr=%0d data=%h, want 2 0 100",
                 log_addr.size() - base, log_addr[log_addr.size()-1], log_data[log_data.size()-1]);
      end
    end
  endtask

  task automatic test_restart();
    int base, b2;
    base = log_addr.size();
    pulse_start();
    send_frame(9'h011, 1'b1); tick(2);
    send_frame(9'h022, 1'b0); tick(4);
    send_frame(9'h033, 1'b1); tick(2);
    send_frame(9'h044, 1'b1); tick(2);
    send_frame(9'h055, 1'b1); tick(2);
    checks++;
    if (RAM_Write_Address !== 3'd4 || Frame_Err !== 1'b1 || log_addr.size() - base !== 4) begin
      errors++;
      $display("FAIL restart_pre: got addr=%0d ferr=%b strobes=%0d, want 4 1 4",
               RAM_Write_Address, Frame_Err, log_addr.size() - base);
    end
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    Ser_In = 1'b0;
    tick(2);
    Load_Start = 1'b1;
    Ser_In = 1'b1;
    tick(1);
    Load_Start = 1'b0;
    checks++;
    if (RAM_Write_Address !== 3'd0 || Frame_Err !== 1'b0 || PC_Enable !== 1'b0 || Loading !== 1'b1) begin
      errors++;
      $display("FAIL restart_state: got addr=%0d ferr=%b pc=%b loading=%b, want 0 0 0 1",
               RAM_Write_Address, Frame_Err, PC_Enable, Loading);
    end
    b2 = log_addr.size();
    tick(40);
    checks++;
    if (log_addr.size() !== b2) begin
      errors++;
      $display("FAIL restart_discard: got %0d strobes, want 0", log_addr.size() - b2);
    end
    send_frame(9'h0F0, 1'b1); tick(4);
    checks++;
    if (log_addr.size() - b2 !== 1 || log_addr[b2] !== 0 || log_data[b2] !== 'h0F0) begin
      errors++;
      $display("FAIL restart_next: got strobes=%0d addr=%0d data=%h, want 1 0 0f0",
               log_addr.size() - b2, log_addr[log_addr.size()-1], log_data[log_data.size()-1]);
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    pulse_start();
    send_frame(9'h1C3, 1'b1); tick(2);
    send_frame(9'h0F0, 1'b0); tick(4);
    checks++;
    if (Frame_Err !== 1'b1 || RAM_Write_Data !== 9'h1C3 || RAM_Write_Address !== 3'd1) begin
      errors++;
      $display("FAIL pre_reset: got ferr=%b data=%h addr=%0d, want 1 1c3 1", Frame_Err, RAM_Write_Data, RAM_Write_Address);
    end
    send_bit(1'b0); send_bit(1'b1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    Ser_In = 1'b1;
    checks++;
    if ({RAM_Write_Data, RAM_Write_Address, RAM_Write_Enable, PC_Enable, CPU_Reset, Loading, Frame_Err} !== 17'd0) begin
      errors++;
      $display("FAIL midframe_reset: got data=%h addr=%0d we=%b pc=%b cpurst=%b loading=%b ferr=%b, want all 0",
               RAM_Write_Data, RAM_Write_Address, RAM_Write_Enable, PC_Enable, CPU_Reset, Loading, Frame_Err);
    end
    base = log_addr.size();
    tick(20);
    checks++;
    if (log_addr.size() !== base || PC_Enable !== 1'b0 || Loading !== 1'b0 || Frame_Err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_quiet: got strobes=%0d pc=%b loading=%b ferr=%b, want 0 0 0 0",
               log_addr.size() - base, PC_Enable, Loading, Frame_Err);
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_run_ignores_line();
    test_frame_err();
    test_glitch();
    test_start_on_strobe();
    test_restart();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
